// File: rtl/rate_tick_controller_pkg.sv
// Shared definitions for the rate tick controller: rate codes, FSM state
// encoding and the half-period length helper used at elaboration.
package rate_pkg;

    typedef enum logic [1:0] {
        RATE_1HZ  = 2'd0,
        RATE_2HZ  = 2'd1,
        RATE_5HZ  = 2'd2,
        RATE_10HZ = 2'd3
    } rate_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN_HI = 2'd1,
        ST_RUN_LO = 2'd2
    } state_e;

    // Number of clk cycles in one half period of the selected rate.
    function automatic int unsigned half_count(input int unsigned clk_hz,
                                               input logic [1:0]  rate);
        case (rate)
            RATE_1HZ: return clk_hz / 2;
            RATE_2HZ: return clk_hz / 4;
            RATE_5HZ: return clk_hz / 10;
            default:  return clk_hz / 20;
        endcase
    endfunction

endpackage

// File: rtl/rate_tick_controller_if.sv
// Rate-select handshake plus tick/square-wave outputs of the controller.
// master = control FSM / tick consumers side, slave = the controller.
interface rate_tick_controller_if;
    logic       run;
    logic       sel_req;
    logic [1:0] sel_rate;
    logic       sel_ack;
    logic       busy;
    logic [1:0] cur_rate;
    logic       sq_out;
    logic       tick;

    modport master (
        output run, sel_req, sel_rate,
        input  sel_ack, busy, cur_rate, sq_out, tick
    );

    modport slave (
        input  run, sel_req, sel_rate,
        output sel_ack, busy, cur_rate, sq_out, tick
    );
endinterface

// File: rtl/rate_tick_controller_counter.sv
// Half-period counter: counts up from 0, wraps to 0 after last_i and flags
// the terminal cycle. clr_i holds it at 0.
module half_period_counter #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] last_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    assign tc_o = !clr_i && (cnt_q == last_i);

    // Count within the half period, restarting at the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i || tc_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/rate_tick_controller.sv
// Rate tick controller: one shared half-period counter produces a 50 % square
// wave and a period-start tick at 1/2/5/10 Hz. Rate changes arrive over a
// req/ack handshake and only land on period boundaries while running.
module rate_tick_controller
    import rate_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int CNT_W  = 26
) (
    input  logic clk,
    input  logic rst_n,
    rate_tick_controller_if.slave bus
);

    // Terminal count (HALF-1) per rate, fixed at elaboration.
    logic [CNT_W-1:0] last_tbl [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_half
            assign last_tbl[gi] = CNT_W'(half_count(CLK_HZ, 2'(gi)) - 1);
        end
    endgenerate

    state_e     state_q;
    logic       sq_q;
    logic       tick_q;
    logic       ack_q;
    logic       busy_q;
    logic [1:0] cur_rate_q;
    logic [1:0] pend_q;

    logic       cnt_clr;
    logic       tc;
    logic       apply_d;
    logic       capture_d;

    // The counter runs only while generating; stopping resets the phase.
    assign cnt_clr = (state_q == ST_IDLE) || !bus.run;

    half_period_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .last_i (last_tbl[cur_rate_q]),
        .tc_o   (tc)
    );

    // A pending rate lands immediately when it cannot disturb the wave
    // (idle, or same rate), otherwise at the next low-to-high boundary or
    // when run drops.
    assign apply_d   = busy_q && ((state_q == ST_IDLE) || (pend_q == cur_rate_q) ||
                                  !bus.run || ((state_q == ST_RUN_LO) && tc));
    assign capture_d = !busy_q && !ack_q && bus.sel_req;

    // Wave FSM: IDLE -> RUN_HI -> RUN_LO -> RUN_HI ..., run=0 returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sq_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sq_q <= 1'b0;
                    if (bus.run) begin
                        state_q <= ST_RUN_HI;
                        sq_q    <= 1'b1;
                        tick_q  <= 1'b1;
                    end
                end
                ST_RUN_HI: begin
                    if (!bus.run) begin
                        state_q <= ST_IDLE;
                        sq_q    <= 1'b0;
                    end else if (tc) begin
                        state_q <= ST_RUN_LO;
                        sq_q    <= 1'b0;
                    end
                end
                ST_RUN_LO: begin
                    if (!bus.run) begin
                        state_q <= ST_IDLE;
                        sq_q    <= 1'b0;
                    end else if (tc) begin
                        state_q <= ST_RUN_HI;
                        sq_q    <= 1'b1;
                        tick_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sq_q    <= 1'b0;
                end
            endcase
        end
    end

    // Request capture and apply; ack is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            cur_rate_q <= RATE_1HZ;
            pend_q     <= RATE_1HZ;
        end else begin
            ack_q <= 1'b0;
            if (apply_d) begin
                cur_rate_q <= pend_q;
                ack_q      <= 1'b1;
                busy_q     <= 1'b0;
            end else if (capture_d) begin
                pend_q <= bus.sel_rate;
                busy_q <= 1'b1;
            end
        end
    end

    assign bus.sq_out   = sq_q;
    assign bus.tick     = tick_q;
    assign bus.sel_ack  = ack_q;
    assign bus.busy     = busy_q;
    assign bus.cur_rate = cur_rate_q;

endmodule

// File: tb/tb_rate_tick_controller.sv
// Testbench for rate_tick_controller at CLK_HZ=100 (HALF = 50/25/10/5).
// Reference model tracks the position inside a full period plus the request
// bookkeeping, and is compared against the DUT every cycle.
module tb_rate_tick_controller;

    localparam int CLK_HZ = 100;
    localparam int CNT_W  = 8;

    logic clk;
    logic rst_n;

    rate_tick_controller_if bus ();

    rate_tick_controller #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    int f_tbl [4] = '{1, 2, 5, 10};
    bit m_run, m_busy, m_ack, m_tick, m_sq;
    int m_pos, m_rate, m_pend;

    function automatic int half(input int r);
        return CLK_HZ / (2 * f_tbl[r]);
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_busy = 0; m_ack = 0; m_tick = 0; m_sq = 0;
        m_pos = 0; m_rate = 0; m_pend = 0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input bit run_i, input bit req_i, input int rate_i);
        bit was_run  = m_run;
        bit boundary = was_run && run_i && (m_pos == 2 * half(m_rate) - 1);
        bit apply    = m_busy && (!was_run || m_pend == m_rate || !run_i || boundary);
        bit capture  = !m_busy && !m_ack && req_i;
        if (!run_i) begin
            m_run = 0; m_pos = 0;
        end else if (!was_run) begin
            m_run = 1; m_pos = 0;
        end else begin
            m_pos = boundary ? 0 : m_pos + 1;
        end
        m_ack = apply;
        if (apply) begin
            m_rate = m_pend; m_busy = 0;
        end else if (capture) begin
            m_pend = rate_i; m_busy = 1;
        end
        m_tick = m_run && (m_pos == 0);
        m_sq   = m_run && (m_pos < half(m_rate));
    endtask

    task automatic compare_all();
        chk("sq_out",   int'(bus.sq_out),   int'(m_sq));
        chk("tick",     int'(bus.tick),     int'(m_tick));
        chk("sel_ack",  int'(bus.sel_ack),  int'(m_ack));
        chk("busy",     int'(bus.busy),     int'(m_busy));
        chk("cur_rate", int'(bus.cur_rate), m_rate);
    endtask

    // Advance one clock, update the model with the pre-edge inputs, check.
    task automatic step();
        @(posedge clk);
        model_edge(bus.run, bus.sel_req, int'(bus.sel_rate));
        #1;
        compare_all();
        if (bus.sel_ack) bus.sel_req = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Step until the DUT shows tick; n = cycles taken.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.tick && n < 300);
        if (!bus.tick) chk("tick_wait_timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sq"},   int'(bus.sq_out),   0);
        chk({tag, "_tick"}, int'(bus.tick),     0);
        chk({tag, "_ack"},  int'(bus.sel_ack),  0);
        chk({tag, "_busy"}, int'(bus.busy),     0);
        chk({tag, "_rate"}, int'(bus.cur_rate), 0);
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        bus.run = 1'b0;
        bus.sel_req = 1'b0;
        bus.sel_rate = 2'd0;
        model_reset();
        #1;
        check_all_zero("reset");
        #21 rst_n = 1'b1;

        // 1 Hz run: first tick one cycle after run, 50/50 phases
        bus.run = 1'b1;
        step();
        chk("first_tick", int'(bus.tick), 1);
        steps(249);

        // Request 10 Hz mid high phase: lands at next period start
        for (int k = 0; k < 200 && !(m_run && m_pos == 20); k++) step();
        bus.sel_rate = 2'd3;
        bus.sel_req  = 1'b1;
        wait_tick(n);
        chk("ack_at_tick", int'(bus.sel_ack), 1);
        wait_tick(n);
        chk("period_10hz", n, 10);
        steps(30);

        // Request 5 Hz while idle: ack two cycles after sel_req
        bus.run = 1'b0;
        steps(3);
        bus.sel_rate = 2'd2;
        bus.sel_req  = 1'b1;
        step();
        step();
        chk("idle_ack", int'(bus.sel_ack), 1);
        chk("idle_rate", int'(bus.cur_rate), 2);
        steps(3);
        bus.run = 1'b1;
        wait_tick(n);
        wait_tick(n);
        chk("period_5hz", n, 20);

        // Request the current rate while running: immediate ack
        steps(7);
        bus.sel_rate = 2'd2;
        bus.sel_req  = 1'b1;
        step();
        step();
        chk("same_rate_ack", int'(bus.sel_ack), 1);
        steps(40);

        // Pending request, then run drops; held second value is not captured
        bus.sel_rate = 2'd0;
        bus.sel_req  = 1'b1;
        step();
        bus.sel_rate = 2'd3;
        steps(2);
        bus.run = 1'b0;
        step();
        chk("stop_ack", int'(bus.sel_ack), 1);
        chk("stop_sq", int'(bus.sq_out), 0);
        chk("stop_rate", int'(bus.cur_rate), 0);
        steps(5);

        // Async reset with a request pending
        bus.run = 1'b1;
        steps(15);
        bus.sel_rate = 2'd1;
        bus.sel_req  = 1'b1;
        steps(2);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        bus.sel_req = 1'b0;
        #2 rst_n = 1'b1;
        steps(120);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if (!bus.sel_req && $urandom_range(0, 19) == 0) begin
                bus.sel_rate = 2'($urandom_range(0, 3));
                bus.sel_req  = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) bus.run = ~bus.run;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
